// File: rtl/apu_run_ctrl_pkg.sv
// Shared definitions for the APU run/halt sequencer: state encodings and counter sizing.
package apu_run_ctrl_pkg;

    // Status-register encoding, also decoded by the IPC register block.
    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_HALTING = 3'd3;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/apu_run_cnt.sv
// Loadable down-counter shared by the reset-hold and halt-timeout phases.
module apu_run_cnt #(
    parameter int unsigned W_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W_CNT-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [W_CNT-1:0] cnt_q;
    logic [W_CNT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/apu_run_ctrl.sv
// APU run/halt sequencer: clock enable, timed reset, run, cooperative halt with timeout.
module apu_run_ctrl
    import apu_run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned HALT_TIMEOUT = 1024,
    parameter int unsigned W_CNT        = cnt_width(RESET_CYCLES, HALT_TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       timeout_clr,
    input  logic       apu_halted,
    input  logic       apu_bus_idle,
    input  logic [1:0] softirq_in,
    output logic       apu_clken,
    output logic       apu_rst_n_o,
    output logic       apu_halt_req,
    output logic [1:0] apu_softirq,
    output logic [2:0] state_o,
    output logic       timeout_flag
);

    localparam logic [W_CNT-1:0] RST_LOAD  = W_CNT'(RESET_CYCLES - 1);
    localparam logic [W_CNT-1:0] HALT_LOAD = W_CNT'(HALT_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic             flag_q, flag_d;
    logic             clken_q, clken_d;
    logic             rstn_q, rstn_d;
    logic             halt_q, halt_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [W_CNT-1:0] cnt_load_val;
    logic             halt_done, forced;

    apu_run_cnt #(.W_CNT(W_CNT)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        flag_d       = flag_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        forced       = 1'b0;
        halt_done    = apu_halted && apu_bus_idle;

        case (state_q)
            ST_OFF: begin
                if (stop_req) begin
                    pending_d = 1'b0;
                end else if (start_req) begin
                    state_d      = ST_RESET;
                    cnt_load     = 1'b1;
                    cnt_load_val = RST_LOAD;
                end
            end
            ST_RESET: begin
                if (stop_req) begin
                    state_d = ST_OFF;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d      = ST_HALTING;
                    cnt_load     = 1'b1;
                    cnt_load_val = HALT_LOAD;
                end
            end
            ST_HALTING: begin
                if (stop_req) begin
                    pending_d = 1'b0;
                end else if (start_req) begin
                    pending_d = 1'b1;
                end
                // Exit decision uses the pending value updated this cycle, so a start
                // on the exit cycle itself still restarts.
                if (halt_done || cnt_zero) begin
                    forced = !halt_done;
                    if (pending_d) begin
                        state_d      = ST_RESET;
                        cnt_load     = 1'b1;
                        cnt_load_val = RST_LOAD;
                        pending_d    = 1'b0;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d   = ST_OFF;
                pending_d = 1'b0;
            end
        endcase

        if (forced) begin
            flag_d = 1'b1;
        end else if (timeout_clr) begin
            flag_d = 1'b0;
        end

        clken_d = (state_d != ST_OFF);
        rstn_d  = (state_d == ST_RUN) || (state_d == ST_HALTING);
        halt_d  = (state_d == ST_HALTING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            pending_q <= 1'b0;
            flag_q    <= 1'b0;
            clken_q   <= 1'b0;
            rstn_q    <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            flag_q    <= flag_d;
            clken_q   <= clken_d;
            rstn_q    <= rstn_d;
            halt_q    <= halt_d;
        end
    end

    assign apu_clken    = clken_q;
    assign apu_rst_n_o  = rstn_q;
    assign apu_halt_req = halt_q;
    assign state_o      = state_q;
    assign timeout_flag = flag_q;
    assign apu_softirq  = softirq_in & {2{state_q == ST_RUN}};

endmodule

// File: tb/tb_apu_run_ctrl.sv
// Self-checking bench for apu_run_ctrl: directed scenarios plus randomized run against a deadline-based model.
module tb_apu_run_ctrl;

    localparam int unsigned RS = 16;
    localparam int unsigned HT = 8;

    logic       clk;
    logic       rst_n;
    logic       start_req, stop_req, timeout_clr;
    logic       apu_halted, apu_bus_idle;
    logic [1:0] softirq_in;
    logic       apu_clken, apu_rst_n_o, apu_halt_req, timeout_flag;
    logic [1:0] apu_softirq;
    logic [2:0] state_o;
    logic [8:0] obs;

    int tests = 0;
    int fails = 0;

    // Model: modes 0=OFF 1=RESET 2=RUN 3=HALTING, timing tracked as absolute cycle deadlines.
    int     m_state;
    longint mcyc, m_release, m_deadline;
    bit     m_pending, m_flag;

    apu_run_ctrl #(.RESET_CYCLES(RS), .HALT_TIMEOUT(HT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .timeout_clr  (timeout_clr),
        .apu_halted   (apu_halted),
        .apu_bus_idle (apu_bus_idle),
        .softirq_in   (softirq_in),
        .apu_clken    (apu_clken),
        .apu_rst_n_o  (apu_rst_n_o),
        .apu_halt_req (apu_halt_req),
        .apu_softirq  (apu_softirq),
        .state_o      (state_o),
        .timeout_flag (timeout_flag)
    );

    assign obs = {state_o, apu_clken, apu_rst_n_o, apu_halt_req, apu_softirq, timeout_flag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; mcyc = 0; m_pending = 0; m_flag = 0;
        m_release = 0; m_deadline = 0;
    endtask

    task automatic model_step();
        bit done, forced;
        if (!rst_n) return;
        done   = apu_halted && apu_bus_idle;
        forced = 0;
        case (m_state)
            0: if (stop_req) m_pending = 0;
               else if (start_req) begin m_state = 1; m_release = mcyc + 1 + RS; end
            1: if (stop_req) m_state = 0;
               else if (mcyc + 1 == m_release) m_state = 2;
            2: if (stop_req) begin m_state = 3; m_deadline = mcyc + 1 + HT; end
            default: begin
                if (stop_req) m_pending = 0;
                else if (start_req) m_pending = 1;
                if (done || (mcyc + 1 == m_deadline)) begin
                    forced = !done;
                    if (m_pending) begin
                        m_state = 1; m_release = mcyc + 1 + RS; m_pending = 0;
                    end else begin
                        m_state = 0;
                    end
                end
            end
        endcase
        if (forced) m_flag = 1;
        else if (timeout_clr) m_flag = 0;
        mcyc++;
    endtask

    function automatic logic [8:0] exp_vec();
        logic [1:0] sq;
        sq = (m_state == 2) ? softirq_in : 2'b00;
        return {3'(m_state), m_state != 0, m_state >= 2, m_state == 3, sq, m_flag};
    endfunction

    function automatic logic [8:0] mk(input int st, input bit ck, input bit rn, input bit hr,
                                      input logic [1:0] sq, input bit fl);
        return {3'(st), ck, rn, hr, sq, fl};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        start_req = 0; stop_req = 0; timeout_clr = 0;
    endtask

    task automatic bring_to_run();
        start_req = 1;
        tick();
        repeat (RS) tick();
        tests++;
        if (state_o !== 3'd2) begin
            fails++; $display("FAIL bring_to_run state: got %0d want 2", state_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start_req = 0; stop_req = 0; timeout_clr = 0;
        apu_halted = 0; apu_bus_idle = 0; softirq_in = 2'b11;
        model_reset();
        #3;
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL reset_values: got %b want %b", obs, 9'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL post_reset_values: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_start_seq();
        logic [8:0] e;
        for (int k = 0; k <= 30; k++) begin
            if (k == 10) start_req = 1;
            e = mk((k < 11) ? 0 : (k < 27) ? 1 : 2, k >= 11, k >= 27, 0,
                   (k >= 27) ? 2'b11 : 2'b00, 0);
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL start_seq cycle %0d: got %b want %b", k, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_halt_complete();
        logic [8:0] e;
        stop_req = 1;
        tick();
        for (int d = 1; d <= 6; d++) begin
            if (d == 5) begin apu_halted = 1; apu_bus_idle = 1; end
            e = mk((d <= 5) ? 3 : 0, d <= 5, d <= 5, d <= 5, 2'b00, 0);
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL halt_complete T+%0d: got %b want %b", d, obs, e);
            end
            tick();
        end
        apu_halted = 0; apu_bus_idle = 0;
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        bring_to_run();
        stop_req = 1;
        tick();
        for (int d = 1; d <= 9; d++) begin
            e = mk((d <= 8) ? 3 : 0, d <= 8, d <= 8, d <= 8, 2'b00, d == 9);
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL timeout T+%0d: got %b want %b", d, obs, e);
            end
            if (d < 9) tick();
        end
        timeout_clr = 1;
        tick();
        tests++;
        if (timeout_flag !== 1'b0) begin
            fails++; $display("FAIL timeout_clr: got %b want 0", timeout_flag);
        end
        bring_to_run();
        stop_req = 1;
        tick();
        for (int d = 1; d <= 8; d++) begin
            if (d == 8) timeout_clr = 1;
            tick();
        end
        e = mk(0, 0, 0, 0, 2'b00, 1);
        tests++;
        if (obs !== e) begin
            fails++; $display("FAIL timeout_set_wins: got %b want %b", obs, e);
        end
        timeout_clr = 1;
        tick();
    endtask

    task automatic test_start_stop_same();
        logic [8:0] e;
        start_req = 1; stop_req = 1;
        tick();
        tick();
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL both_in_off: got %b want %b", obs, 9'b0);
        end
        start_req = 1;
        tick();
        repeat (3) tick();
        start_req = 1; stop_req = 1;
        tick();
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL both_in_reset: got %b want %b", obs, 9'b0);
        end
        bring_to_run();
        start_req = 1; stop_req = 1;
        tick();
        e = mk(3, 1, 1, 1, 2'b00, 0);
        tests++;
        if (obs !== e) begin
            fails++; $display("FAIL both_in_run: got %b want %b", obs, e);
        end
        apu_halted = 1; apu_bus_idle = 1;
        tick();
        apu_halted = 0; apu_bus_idle = 0;
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL both_no_restart: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_restart();
        logic [8:0] e;
        bring_to_run();
        stop_req = 1;
        tick();
        start_req = 1;
        tick();
        tick();
        apu_halted = 1; apu_bus_idle = 1;
        e = mk(3, 1, 1, 1, 2'b00, 0);
        tests++;
        if (obs !== e) begin
            fails++; $display("FAIL restart_halting: got %b want %b", obs, e);
        end
        tick();
        apu_halted = 0; apu_bus_idle = 0;
        for (int j = 0; j <= int'(RS); j++) begin
            e = mk((j < int'(RS)) ? 1 : 2, 1, j >= int'(RS), 0,
                   (j >= int'(RS)) ? 2'b11 : 2'b00, 0);
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL restart_seq E+%0d: got %b want %b", j, obs, e);
            end
            tick();
        end
        stop_req = 1;
        tick();
        start_req = 1;
        tick();
        stop_req = 1;
        tick();
        apu_halted = 1; apu_bus_idle = 1;
        tick();
        apu_halted = 0; apu_bus_idle = 0;
        tick();
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL restart_cancelled: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        start_req = 1;
        tick();
        repeat (5) tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL async_mid_reset: got %b want %b", obs, 9'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        bring_to_run();
        stop_req = 1;
        repeat (9) tick();
        tests++;
        if (timeout_flag !== 1'b1) begin
            fails++; $display("FAIL async_pre_flag: got %b want 1", timeout_flag);
        end
        bring_to_run();
        stop_req = 1;
        tick();
        start_req = 1;
        tick();
        tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        tests++;
        if (obs !== 9'b0) begin
            fails++; $display("FAIL async_mid_halting: got %b want %b", obs, 9'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        bring_to_run();
        stop_req = 1;
        tick();
        apu_halted = 1; apu_bus_idle = 1;
        tick();
        apu_halted = 0; apu_bus_idle = 0;
        e = mk(0, 0, 0, 0, 2'b00, 0);
        tests++;
        if (obs !== e) begin
            fails++; $display("FAIL async_pending_cleared: got %b want %b", obs, e);
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        for (int i = 0; i < 3000; i++) begin
            e = exp_vec();
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL random cycle %0d: got %b want %b", i, obs, e);
            end
            start_req   = ($urandom_range(0, 7) == 0);
            stop_req    = ($urandom_range(0, 19) == 0);
            timeout_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) apu_halted = ~apu_halted;
            if ($urandom_range(0, 9) == 0) apu_bus_idle = ~apu_bus_idle;
            softirq_in = 2'($urandom);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_start_seq();
        test_halt_complete();
        test_timeout();
        test_start_stop_same();
        test_restart();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
